data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the wait cycles inserted between request acceptance and response (range 0..15).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = in reset).
REQ-005 The block SHALL have port req_valid, input, 1 bit, meaning the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit, meaning the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32 bits, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits, the store data.
REQ-010 The block SHALL have port req_wstrb, input, 4 bits, the byte-lane write enables (bit i writes bits 8i+7:8i).
REQ-011 The block SHALL have port rsp_valid, output, 1 bit, meaning the response is available.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit, meaning the initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits, the load data (0 for stores and errors).
REQ-014 The block SHALL have port rsp_err, output, 1 bit, meaning the request was misaligned or out of range.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a request is accepted at edge E0 where req_valid=1 and req_ready=1, and all req_* fields are captured at E0.
REQ-017 At acceptance the FSM SHALL go to WAIT with a down-counter loaded with LATENCY-1 when LATENCY>0, and directly to RESP when LATENCY=0.
REQ-018 In WAIT the counter SHALL decrement each cycle, and at count 0 the FSM SHALL move to RESP on the next edge, so rsp_valid is first high in the cycle after edge E0+LATENCY.
REQ-019 The storage read and the byte-masked write SHALL both occur at the edge entering RESP, and rsp_rdata/rsp_err SHALL be registered at that edge.
REQ-020 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1, after which the FSM returns to IDLE on that edge (back-pressure holds indefinitely).
REQ-021 Only one transaction SHALL be outstanding at a time, so the minimum occupancy is LATENCY+2 cycles per transaction.
REQ-022 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2].
REQ-023 The error condition is req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS; on error rsp_err=1, rsp_rdata=0 and storage SHALL NOT be written.
REQ-024 A store with req_wstrb=0 SHALL be a no-op returning rsp_err=0.
REQ-025 For a store, rsp_rdata SHALL be 0.
REQ-026 A load after a store to the same word SHALL return the post-store value.
REQ-027 Changes on the req_* inputs after acceptance SHALL be ignored.

Reset
REQ-028 While reset=0, the block SHALL force state IDLE, the counter to 0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-029 req_ready SHALL rise in the first cycle after reset deasserts.
REQ-030 A reset during WAIT or RESP SHALL drop the transaction; a store not yet committed SHALL NOT modify storage.
REQ-031 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-032 The shared Verilog header SHALL hold XLEN=32, the FSM state encodings and the strobe width; the block parameters stay local.
REQ-033 The storage SHALL be a sub-module data_mem_array: a synchronous, byte-enabled, single-port word array with no reset.

Verification
REQ-034 Scenario: with LATENCY=2, store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then load 0x10 -> rsp_valid is seen 2 edges after acceptance, and the load returns 0xDEADBEEF with err=0.
REQ-035 Scenario: partial strobe, storing 0x000000AA with wstrb 0x1 over 0xDEADBEEF, then a load -> 0xDEADBEAA.
REQ-036 Scenario: load 0x12 (misaligned) and load 0x1000 (DEPTH 1024) -> err=1 and rdata=0; a following load of 0x0FFC succeeds with err=0.
REQ-037 Scenario: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0 throughout, and req_ready=1 in the cycle after the rsp handshake.
REQ-038 Scenario: LATENCY=0, back-to-back requests with rsp_ready=1 -> one transaction every 2 cycles.
REQ-039 Scenario: store 0x55 to 0x20, then assert reset in WAIT -> rsp_valid=0, and a later load of 0x20 returns the old value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared word width, strobe width and responder FSM states.
package data_mem_responder_pkg;
  localparam int XLEN = 32;
  localparam int STRB_W = XLEN / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/data_mem_array.sv
// data_mem_array: synchronous byte-enabled single-port word store, no reset.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [STRB_W-1:0] i_be,
  input  logic [AW-1:0]     i_idx,
  input  logic [XLEN-1:0]   i_wdata,
  output logic [XLEN-1:0]   o_rdata
);
  logic [XLEN-1:0] r_mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < STRB_W; b++)
        if (i_we && i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      o_rdata <= r_mem[i_idx];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding memory responder with fixed wait latency.
// Access happens on the edge entering RESP; response held until rsp_ready.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_LD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic r_write, r_err, r_ld_ok;
  logic [XLEN-1:0] r_addr, r_wdata, w_addr, w_wdata, w_mem_rdata;
  logic [STRB_W-1:0] r_wstrb, w_wstrb;
  logic w_idle, w_acc, w_go, w_write, w_err;
  assign w_idle = r_state == IDLE;
  assign req_ready = w_idle & reset;
  assign w_acc = req_valid & req_ready;
  assign w_go = (w_acc && LATENCY == 0) || (r_state == WAIT && r_cnt == 4'd0);
  // Zero-latency requests commit straight from the live request fields.
  assign w_write = w_idle ? req_write : r_write;
  assign w_addr = w_idle ? req_addr : r_addr;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_wstrb = w_idle ? req_wstrb : r_wstrb;
  assign w_err = (|w_addr[1:0]) || (|w_addr[XLEN-1:AW+2]);
  assign rsp_valid = r_state == RESP;
  assign rsp_err = r_err;
  assign rsp_rdata = r_ld_ok ? w_mem_rdata : '0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_acc) w_next = (LATENCY == 0) ? RESP : WAIT;
      WAIT: if (r_cnt == 4'd0) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_ld_ok <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) r_cnt <= LAT_LD;
      else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_go) begin
        r_err <= w_err;
        r_ld_ok <= ~w_write & ~w_err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_write <= req_write;
      r_addr <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end
  data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
    .clk    (clk),
    .i_en   (w_go),
    .i_we   (w_write & ~w_err),
    .i_be   (w_wstrb),
    .i_idx  (w_addr[AW+1:2]),
    .i_wdata(w_wdata),
    .o_rdata(w_mem_rdata)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table vectors, corner sequences and random traffic vs a word-array model.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic req_valid = 0, req_write = 0, rsp_ready = 0, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic [3:0] req_wstrb = 0;
  logic z_req_valid = 0, z_req_write = 0, z_rsp_ready = 0, z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_req_addr = 0, z_req_wdata = 0, z_rsp_rdata;
  logic [3:0] z_req_wstrb = 0;
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb), .rsp_valid(z_rsp_valid),
    .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );
  int n_chk = 0, n_pass = 0;
  logic [31:0] mdl [16];
  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0] strb;
    logic [31:0] rdata;
    bit err;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model over words 64..79 (byte addresses 0x100..0x13C).
  function automatic void model(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] st, output logic [31:0] rd, output bit er);
    int w;
    er = (a % 4 != 0) || (a >= 4 * DEPTH);
    rd = 0;
    if (er) return;
    w = int'(a / 4) - 64;
    if (wr) begin
      for (int b = 0; b < 4; b++) if (st[b]) mdl[w][8*b +: 8] = wd[8*b +: 8];
    end else rd = mdl[w];
  endfunction

  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input int hold, input logic [31:0] erd, input bit eer);
    int n;
    @(negedge clk);
    req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd; req_wstrb = st;
    rsp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(n < 50), 1);
    @(posedge clk); #1;
    req_valid = 0; req_write = ~wr; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 50);
    chk("latency", n, LAT);
    chk("rdata", rsp_rdata, erd);
    chk("err", 32'(rsp_err), 32'(eer));
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_rdata", rsp_rdata, erd);
      chk("bp_err", 32'(rsp_err), 32'(eer));
      chk("bp_req_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    chk("ready_after_rsp", 32'(req_ready), 1);
    chk("valid_after_rsp", 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [31:0] erd, v, a, last;
    bit eer, wr;
    int n, acc, rv, prev, dbl;
    tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    tbl[4]  = '{1'b0, 32'h12,   32'h0,        4'h0, 32'h0, 1'b1};
    tbl[5]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0, 1'b1};
    tbl[6]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
    tbl[7]  = '{1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0, 1'b1};
    tbl[8]  = '{1'b1, 32'h11,   32'hFFFFFFFF, 4'hF, 32'h0, 1'b1};
    tbl[9]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    tbl[11] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    tbl[12] = '{1'b1, 32'hFFC,  32'h0F0F1234, 4'hF, 32'h0, 1'b0};
    tbl[13] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h0F0F1234, 1'b0};
    tbl[14] = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_z_req_ready", 32'(z_req_ready), 0);
    reset = 1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(req_ready), 1);
    foreach (tbl[i]) txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb, 0, tbl[i].rdata, tbl[i].err);
    txn(0, 32'h10, 0, 0, 5, 32'hDEADBEAA, 0);
    // Reset while a store sits in WAIT must leave storage untouched.
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h20; req_wdata = 32'h55; req_wstrb = 4'hF; rsp_ready = 1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("wait_rst_accept", 32'(n < 50), 1);
    @(posedge clk); #1;
    req_valid = 0;
    #2 reset = 0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_req_ready", 32'(req_ready), 0);
    chk("midrst_rdata", rsp_rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    chk("midrst_no_rsp", 32'(rsp_valid), 0);
    chk("midrst_ready", 32'(req_ready), 1);
    txn(0, 32'h20, 0, 0, 0, 32'h11223344, 0);
    for (int w = 0; w < 16; w++) begin
      v = $urandom;
      a = 32'h100 + 32'(4 * w);
      model(1, a, v, 4'hF, erd, eer);
      txn(1, a, v, 4'hF, 0, erd, eer);
    end
    for (int i = 0; i < 200; i++) begin
      n = $urandom_range(0, 9);
      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
      if (n == 0) a = a + 32'($urandom_range(1, 3));
      else if (n == 1) a = 32'h1000 + ($urandom & 32'h7FFFFFFF);
      wr = 1'($urandom);
      v = $urandom;
      req_wstrb = 4'($urandom);
      model(wr, a, v, req_wstrb, erd, eer);
      txn(wr, a, v, req_wstrb, $urandom_range(0, 3), erd, eer);
    end
    // Zero-latency instance: back-to-back stores with the response always accepted.
    @(negedge clk);
    z_rsp_ready = 1; z_req_write = 1; z_req_wstrb = 4'hF; z_req_addr = 32'h40; z_req_valid = 1;
    acc = 0; rv = 0; prev = -5; dbl = 0; last = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      z_req_wdata = 32'(i) * 32'h01010101 + 32'h7;
      if (z_req_ready) begin
        if (i - prev < 2) dbl++;
        prev = i; acc++; last = z_req_wdata;
      end
      if (z_rsp_valid) rv++;
    end
    @(posedge clk); #1;
    z_req_valid = 0;
    chk("z_accepts", acc, 10);
    chk("z_responses", rv, 10);
    chk("z_spacing", dbl, 0);
    n = 0;
    @(negedge clk);
    while (!z_req_ready && n < 50) begin @(negedge clk); n++; end
    z_req_write = 0; z_req_valid = 1;
    @(posedge clk); #1;
    z_req_valid = 0;
    chk("z_rsp_next_cycle", 32'(z_rsp_valid), 1);
    chk("z_load_rdata", z_rsp_rdata, last);
    chk("z_load_err", 32'(z_rsp_err), 0);
    @(posedge clk); #1;
    chk("z_ready_after", 32'(z_req_ready), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
